tpu_cmd_sched: RTL and testbench
================================

// Module: tpu_cmd_sched
// PURPOSE
//  Host-command sequencer for the 4x4 systolic TPU core. Accepts CFU-style commands that
//  configure K/M/N/InputOffset, fill the A/B global buffers, launch a run, and read C
//  back 32 bits at a time. Owns the host side of the buffer ports. Drives the select
//  line that hands buffer ownership to the TPU for the duration of a run.
// PARAMETERS
//  ADDR_W   12   buffer index width (A/B/C)
//  C_W      128  C buffer word width (4 x 32-bit accumulators)
//  TMO_W    20   watchdog counter width; run aborts after 2^TMO_W-1 cycles busy
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       command accepted when valid&&ready
//  cmd_funct     in   7       opcode (see BEHAVIOUR)
//  cmd_in0       in   32      operand 0
//  cmd_in1       in   32      operand 1
//  rsp_valid     out  1       response present; held until rsp_ready
//  rsp_ready     in   1       host consumes response
//  rsp_out       out  32      response data
//  tpu_in_valid  out  1       one-cycle start pulse to TPU
//  tpu_K/M/N     out  8 each  run dimensions, registered, stable outside SET_CFG
//  tpu_offset    out  9       InputOffset, registered
//  tpu_busy      in   1       TPU busy flag
//  buf_sel_tpu   out  1       1: top-level mux gives A/B/C ports to TPU
//  a_wr_en/b_wr_en out 1      host buffer write strobes
//  ab_index      out  ADDR_W  host A/B write index
//  ab_data       out  32      host A/B write data
//  c_index       out  ADDR_W  host C read index
//  c_data        in   C_W     C read data, valid 1 cycle after c_index
// BEHAVIOUR
//  Reset: all outputs 0; tpu_K/M/N/offset=0; state IDLE; cycle counter 0.
//  Single outstanding command: cmd_ready=1 only in IDLE, and only when rsp_valid=0.
//  Opcodes (cmd_funct):
//   0 SET_CFG : K=in0[7:0], M=in0[15:8], N=in0[23:16], offset=in1[8:0]; rsp=0
//   1 WR_A    : a_wr_en=1 one cycle, ab_index=in0[ADDR_W-1:0], ab_data=in1; rsp=0
//   2 WR_B    : same with b_wr_en
//   3 START   : if K,M,N all nonzero, launch run; rsp=busy cycle count. Else rsp=32'hFFFF_FFFE, no pulse
//   4 RD_C    : c_index=in0[ADDR_W-1:0]; lane=in1[1:0]; rsp=c_data lane
//               lane 0=[127:96], lane 1=[95:64], lane 2=[63:32], lane 3=[31:0]
//   5 STATUS  : rsp={27'd0, buf_sel_tpu, tpu_busy, last_run_timed_out, 2'd0}
//   other     : rsp=32'hFFFF_FFFF
//  FSM states:
//   IDLE -> WRITE | PULSE | RD_ADDR | RESP, on accept
//   WRITE   : 1 cycle -> RESP
//   PULSE   : tpu_in_valid=1, buf_sel_tpu=1 -> WAIT_HI
//   WAIT_HI : wait for tpu_busy=1 -> RUN. If busy not seen within 4 cycles -> RESP with 32'hFFFF_FFFD
//   RUN     : count cycles while busy. busy=0 -> RESP
//             counter reaching all-ones -> RESP with 32'hDEAD_0000, timed_out flag set
//   RD_ADDR : drive c_index -> RD_DATA
//   RD_DATA : capture lane -> RESP
//   RESP    : rsp_valid=1 -> IDLE on rsp_ready
//  buf_sel_tpu rises in PULSE and falls the cycle after busy falls or timeout.
//  Host strobes are forced 0 whenever buf_sel_tpu=1.
//  Response is registered at RESP entry. rsp_out is stable while rsp_valid && !rsp_ready.
//  Fastest response timing: RESP entered the cycle after accept for SET_CFG and unknown
//  opcodes, and 2 cycles after accept for WR_*.
//  Cycle count: 32-bit, saturating, counts cycles with tpu_busy=1 in RUN.
//  Reset mid-run drops everything at once; the TPU is reset by the same rst_n.
//  cmd_valid while not ready is ignored; inputs are sampled only on accept.
// STRUCTURE
//  Package tpu_ctrl_pkg: funct codes, FSM state encoding, response/error codes, lane map.
//  No sub-module. Flat FSM plus counters; top-level mux is outside this block.
// TESTING
//  1 SET_CFG in0=0x00080808, in1=0x080 -> tpu_K=M=N=8, tpu_offset=128, rsp=0
//  2 WR_A idx=5 data=0x01020304 -> a_wr_en high exactly 1 cycle, ab_index=5, rsp=0
//  3 START with model TPU busy 37 cycles -> exactly one in_valid pulse, rsp=37, buf_sel_tpu back to 0
//  4 START after SET_CFG with K=0 -> no in_valid, rsp=0xFFFFFFFE
//  5 RD_C idx=2 lane=3, c_data[31:0]=0xCAFE -> rsp=0x0000CAFE
//  6 rst_n low during RUN -> all outputs 0 async; hold rsp_ready=0 for 5 cycles -> rsp stable

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// Shared encodings for the TPU host-command sequencer: opcodes, FSM states,
// response codes and the C-buffer lane map.
package tpu_ctrl_pkg;

  localparam logic [6:0] F_SET_CFG = 7'd0;
  localparam logic [6:0] F_WR_A    = 7'd1;
  localparam logic [6:0] F_WR_B    = 7'd2;
  localparam logic [6:0] F_START   = 7'd3;
  localparam logic [6:0] F_RD_C    = 7'd4;
  localparam logic [6:0] F_STATUS  = 7'd5;

  localparam logic [31:0] RSP_OK      = 32'h0000_0000;
  localparam logic [31:0] RSP_BAD_OP  = 32'hFFFF_FFFF;
  localparam logic [31:0] RSP_BAD_DIM = 32'hFFFF_FFFE;
  localparam logic [31:0] RSP_NO_BUSY = 32'hFFFF_FFFD;
  localparam logic [31:0] RSP_TIMEOUT = 32'hDEAD_0000;

  // WAIT_HI gives the TPU this many extra cycles (4 in total) to raise busy
  localparam logic [1:0] HI_WAIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_PULSE,
    S_WAIT_HI,
    S_RUN,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESP
  } state_e;

  // Lane 0 is the most significant accumulator of the 128-bit C word
  function automatic logic [31:0] lane_word(input logic [127:0] c, input logic [1:0] lane);
    logic [31:0] w;
    case (lane)
      2'd0:    w = c[127:96];
      2'd1:    w = c[95:64];
      2'd2:    w = c[63:32];
      default: w = c[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tpu_cmd_sched.sv
// Host-command sequencer for the 4x4 systolic TPU: configuration, A/B buffer fill,
// run launch with busy-cycle count and watchdog, and 32-bit C readback.
//
// state    | meaning
// IDLE     | ready for a command (when no response pending)
// WRITE    | one-cycle host A/B write strobe
// PULSE    | start pulse to TPU, buffers handed to TPU
// WAIT_HI  | waiting up to 4 cycles for TPU busy
// RUN      | counting busy cycles, watchdog armed
// RD_ADDR  | C index driven to buffer
// RD_DATA  | C data returned, lane captured
// RESP     | response held until host consumes it
module tpu_cmd_sched
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int C_W    = 128,
  parameter int TMO_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_funct,
  input  logic [31:0]       cmd_in0,
  input  logic [31:0]       cmd_in1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_out,
  output logic              tpu_in_valid,
  output logic [7:0]        tpu_K,
  output logic [7:0]        tpu_M,
  output logic [7:0]        tpu_N,
  output logic [8:0]        tpu_offset,
  input  logic              tpu_busy,
  output logic              buf_sel_tpu,
  output logic              a_wr_en,
  output logic              b_wr_en,
  output logic [ADDR_W-1:0] ab_index,
  output logic [31:0]       ab_data,
  output logic [ADDR_W-1:0] c_index,
  input  logic [C_W-1:0]    c_data
);

  state_e              state_q, state_d;
  logic [7:0]          k_q, k_d, m_q, m_d, n_q, n_d;
  logic [8:0]          off_q, off_d;
  logic                is_b_q, is_b_d;
  logic [ADDR_W-1:0]   ab_index_q, ab_index_d;
  logic [31:0]         ab_data_q, ab_data_d;
  logic [ADDR_W-1:0]   c_index_q, c_index_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         rsp_q, rsp_d;
  logic                buf_sel_q, buf_sel_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [TMO_W-1:0]    wd_q, wd_d;
  logic [TMO_W-1:0]    wd_nxt;
  logic [1:0]          hi_q, hi_d;
  logic                tmo_q, tmo_d;

  logic unused_in0_hi;
  assign unused_in0_hi = ^cmd_in0[31:24];

  assign wd_nxt = wd_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    m_d        = m_q;
    n_d        = n_q;
    off_d      = off_q;
    is_b_d     = is_b_q;
    ab_index_d = ab_index_q;
    ab_data_d  = ab_data_q;
    c_index_d  = c_index_q;
    lane_d     = lane_q;
    rsp_d      = rsp_q;
    buf_sel_d  = buf_sel_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    hi_d       = hi_q;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_funct)
            F_SET_CFG: begin
              k_d     = cmd_in0[7:0];
              m_d     = cmd_in0[15:8];
              n_d     = cmd_in0[23:16];
              off_d   = cmd_in1[8:0];
              rsp_d   = RSP_OK;
              state_d = S_RESP;
            end
            F_WR_A, F_WR_B: begin
              ab_index_d = cmd_in0[ADDR_W-1:0];
              ab_data_d  = cmd_in1;
              is_b_d     = (cmd_funct == F_WR_B);
              state_d    = S_WRITE;
            end
            F_START: begin
              if ((k_q != 8'd0) && (m_q != 8'd0) && (n_q != 8'd0)) begin
                buf_sel_d = 1'b1;
                cnt_d     = 32'd0;
                wd_d      = '0;
                tmo_d     = 1'b0;
                state_d   = S_PULSE;
              end else begin
                rsp_d   = RSP_BAD_DIM;
                state_d = S_RESP;
              end
            end
            F_RD_C: begin
              c_index_d = cmd_in0[ADDR_W-1:0];
              lane_d    = cmd_in1[1:0];
              state_d   = S_RD_ADDR;
            end
            F_STATUS: begin
              rsp_d   = {27'd0, buf_sel_q, tpu_busy, tmo_q, 2'b00};
              state_d = S_RESP;
            end
            default: begin
              rsp_d   = RSP_BAD_OP;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_WRITE: begin
        rsp_d   = RSP_OK;
        state_d = S_RESP;
      end
      S_PULSE: begin
        hi_d    = 2'd0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // The first busy cycle is seen here, so it is counted here too
        if (tpu_busy) begin
          cnt_d   = 32'd1;
          wd_d    = {{(TMO_W-1){1'b0}}, 1'b1};
          state_d = S_RUN;
        end else if (hi_q == HI_WAIT_LAST) begin
          rsp_d     = RSP_NO_BUSY;
          buf_sel_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          hi_d = hi_q + 2'd1;
        end
      end
      S_RUN: begin
        if (!tpu_busy) begin
          rsp_d     = cnt_q;
          buf_sel_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
          wd_d  = wd_nxt;
          if (wd_nxt == {TMO_W{1'b1}}) begin
            rsp_d     = RSP_TIMEOUT;
            tmo_d     = 1'b1;
            buf_sel_d = 1'b0;
            state_d   = S_RESP;
          end
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: begin
        rsp_d   = lane_word(c_data[127:0], lane_q);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      off_q      <= '0;
      is_b_q     <= 1'b0;
      ab_index_q <= '0;
      ab_data_q  <= '0;
      c_index_q  <= '0;
      lane_q     <= '0;
      rsp_q      <= '0;
      buf_sel_q  <= 1'b0;
      cnt_q      <= '0;
      wd_q       <= '0;
      hi_q       <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      m_q        <= m_d;
      n_q        <= n_d;
      off_q      <= off_d;
      is_b_q     <= is_b_d;
      ab_index_q <= ab_index_d;
      ab_data_q  <= ab_data_d;
      c_index_q  <= c_index_d;
      lane_q     <= lane_d;
      rsp_q      <= rsp_d;
      buf_sel_q  <= buf_sel_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      hi_q       <= hi_d;
      tmo_q      <= tmo_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_out      = rsp_q;
  assign tpu_in_valid = (state_q == S_PULSE);
  assign tpu_K        = k_q;
  assign tpu_M        = m_q;
  assign tpu_N        = n_q;
  assign tpu_offset   = off_q;
  assign buf_sel_tpu  = buf_sel_q;
  assign a_wr_en      = (state_q == S_WRITE) && !is_b_q && !buf_sel_q;
  assign b_wr_en      = (state_q == S_WRITE) &&  is_b_q && !buf_sel_q;
  assign ab_index     = ab_index_q;
  assign ab_data      = ab_data_q;
  assign c_index      = c_index_q;

endmodule

// File: tb/tb_tpu_cmd_sched.sv
// Randomized command-level bench for tpu_cmd_sched with a behavioural TPU, a C buffer
// memory and a response model derived from the command semantics.
module tb_tpu_cmd_sched;

  localparam int ADDR_W  = 12;
  localparam int C_W     = 128;
  localparam int TMO_W   = 6;
  localparam int TMO_LIM = (1 << TMO_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [6:0]        cmd_funct;
  logic [31:0]       cmd_in0;
  logic [31:0]       cmd_in1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_out;
  logic              tpu_in_valid;
  logic [7:0]        tpu_K, tpu_M, tpu_N;
  logic [8:0]        tpu_offset;
  logic              tpu_busy;
  logic              buf_sel_tpu;
  logic              a_wr_en, b_wr_en;
  logic [ADDR_W-1:0] ab_index;
  logic [31:0]       ab_data;
  logic [ADDR_W-1:0] c_index;
  logic [C_W-1:0]    c_data;

  tpu_cmd_sched #(.ADDR_W(ADDR_W), .C_W(C_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
    .cmd_in0(cmd_in0), .cmd_in1(cmd_in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .tpu_in_valid(tpu_in_valid), .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N),
    .tpu_offset(tpu_offset), .tpu_busy(tpu_busy), .buf_sel_tpu(buf_sel_tpu),
    .a_wr_en(a_wr_en), .b_wr_en(b_wr_en), .ab_index(ab_index), .ab_data(ab_data),
    .c_index(c_index), .c_data(c_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // C buffer: synchronous read, data one cycle after index
  logic [127:0] mem [0:4095];
  always @(posedge clk) c_data <= mem[c_index];

  // TPU: after the start pulse, idle for tpu_delay cycles then busy for tpu_len cycles
  int tpu_delay = 0;
  int tpu_len   = 0;
  int pre_q     = 0;
  int rem_q     = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= 0;
      rem_q <= 0;
    end else if (tpu_in_valid) begin
      pre_q <= tpu_delay;
      rem_q <= tpu_len;
    end else if (pre_q > 0) begin
      pre_q <= pre_q - 1;
    end else if (rem_q > 0) begin
      rem_q <= rem_q - 1;
    end
  end
  assign tpu_busy = (pre_q == 0) && (rem_q > 0);

  int a_pulses = 0, b_pulses = 0, iv_pulses = 0, iv_nosel = 0;
  logic [ADDR_W-1:0] last_idx = '0;
  logic [31:0]       last_data = '0;
  always @(posedge clk) begin
    if (a_wr_en || b_wr_en) begin
      last_idx  <= ab_index;
      last_data <= ab_data;
    end
    if (a_wr_en) a_pulses <= a_pulses + 1;
    if (b_wr_en) b_pulses <= b_pulses + 1;
    if (tpu_in_valid) iv_pulses <= iv_pulses + 1;
    if (tpu_in_valid && !buf_sel_tpu) iv_nosel <= iv_nosel + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mk = 0, mm = 0, mn = 0;
  logic [8:0] moff = 0;
  logic       mtmo = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait for its response, check it (and its stability while held)
  task automatic issue(input logic [6:0] f, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] exp, input int hold, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_funct = f;
    cmd_in0   = i0;
    cmd_in1   = i1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_funct = 7'($urandom);
    cmd_in0   = $urandom;
    cmd_in1   = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 3000);
    check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
    check("rsp", rsp_out, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, rsp_out[30:0]}, {1'b1, exp[30:0]});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [6:0] f, input logic [31:0] i0, input logic [31:0] i1,
                         input int hold);
    logic [31:0]  exp;
    logic [127:0] sh;
    bit           launch;
    int a0, b0, v0, lat, n;
    a0 = a_pulses;
    b0 = b_pulses;
    v0 = iv_pulses;
    launch = 0;
    case (f)
      7'd0, 7'd1, 7'd2: exp = 32'd0;
      7'd3: begin
        if (mk == 0 || mm == 0 || mn == 0) exp = 32'hFFFF_FFFE;
        else begin
          launch = 1;
          if (tpu_delay > 3 || tpu_len == 0) exp = 32'hFFFF_FFFD;
          else if (tpu_len >= TMO_LIM)       exp = 32'hDEAD_0000;
          else                               exp = 32'(tpu_len);
        end
      end
      7'd4: begin
        sh  = mem[i0[ADDR_W-1:0]] >> (96 - 32 * int'(i1[1:0]));
        exp = sh[31:0];
      end
      7'd5:    exp = mtmo ? 32'h4 : 32'h0;
      default: exp = 32'hFFFF_FFFF;
    endcase
    issue(f, i0, i1, exp, hold, lat);
    case (f)
      7'd0: begin
        mk = i0[7:0]; mm = i0[15:8]; mn = i0[23:16]; moff = i1[8:0];
        check("cfg_K", 32'(tpu_K), 32'(mk));
        check("cfg_M", 32'(tpu_M), 32'(mm));
        check("cfg_N", 32'(tpu_N), 32'(mn));
        check("cfg_off", 32'(tpu_offset), 32'(moff));
        check("lat_cfg", 32'(lat), 32'd1);
      end
      7'd1, 7'd2: begin
        check("wr_a_cnt", 32'(a_pulses - a0), (f == 7'd1) ? 32'd1 : 32'd0);
        check("wr_b_cnt", 32'(b_pulses - b0), (f == 7'd2) ? 32'd1 : 32'd0);
        check("wr_idx", 32'(last_idx), 32'(i0[ADDR_W-1:0]));
        check("wr_data", last_data, i1);
        check("lat_wr", 32'(lat), 32'd2);
      end
      7'd3: begin
        check("start_pulses", 32'(iv_pulses - v0), launch ? 32'd1 : 32'd0);
        check("sel_after", {31'd0, buf_sel_tpu}, 32'd0);
        if (launch) mtmo = (exp == 32'hDEAD_0000);
        n = 0;
        while ((pre_q != 0 || rem_q != 0) && n < 500) begin
          @(negedge clk);
          n++;
        end
      end
      7'd4, 7'd5: ;
      default: check("lat_bad_op", 32'(lat), 32'd1);
    endcase
  endtask

  initial begin
    logic [31:0] i0, i1;
    int r, n, lat;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_funct = '0;
    cmd_in0   = '0;
    cmd_in1   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_out", rsp_out, 32'd0);
    check("rst_dims", {tpu_K, tpu_M, tpu_N, 8'd0}, 32'd0);
    check("rst_ctl", {28'd0, tpu_in_valid, buf_sel_tpu, a_wr_en, b_wr_en}, 32'd0);
    rst_n = 1'b1;

    run_cmd(7'd0, 32'h0008_0808, 32'h0000_0080, 0);
    run_cmd(7'd1, 32'd5, 32'h0102_0304, 1);
    tpu_delay = 0; tpu_len = 37;
    run_cmd(7'd3, 32'd0, 32'd0, 2);
    check("no_pulse_without_sel", 32'(iv_nosel), 32'd0);
    run_cmd(7'd0, 32'h0008_0800, 32'h0000_0010, 0);
    run_cmd(7'd3, 32'd0, 32'd0, 0);
    mem[2][31:0] = 32'h0000_CAFE;
    run_cmd(7'd4, 32'd2, 32'd3, 5);
    run_cmd(7'd0, 32'h0001_0203, 32'h0000_01FF, 0);
    tpu_delay = 1; tpu_len = 70;
    run_cmd(7'd3, 32'd0, 32'd0, 0);
    run_cmd(7'd5, 32'd0, 32'd0, 1);

    for (int it = 0; it < 70; it++) begin
      r  = $urandom_range(0, 9);
      i0 = $urandom;
      i1 = $urandom;
      case (r)
        0, 1: begin
          i0[7:0]   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          i0[15:8]  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          i0[23:16] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          run_cmd(7'd0, i0, i1, $urandom_range(0, 3));
        end
        2: run_cmd(7'd1, i0, i1, $urandom_range(0, 3));
        3: run_cmd(7'd2, i0, i1, $urandom_range(0, 3));
        4, 5: begin
          tpu_delay = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
          tpu_len   = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 45);
          run_cmd(7'd3, i0, i1, $urandom_range(0, 3));
        end
        6, 7: run_cmd(7'd4, i0, i1, $urandom_range(0, 3));
        8: run_cmd(7'd5, i0, i1, $urandom_range(0, 3));
        default: run_cmd(7'($urandom_range(6, 127)), i0, i1, $urandom_range(0, 3));
      endcase
    end
    check("no_pulse_without_sel_end", 32'(iv_nosel), 32'd0);

    // Reset in the middle of a run
    run_cmd(7'd0, 32'h0004_0302, 32'h0000_0011, 0);
    tpu_delay = 0; tpu_len = 40;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_funct = 7'd3; cmd_in0 = '0; cmd_in1 = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!tpu_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("sel_in_run", {31'd0, buf_sel_tpu}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctl", {27'd0, rsp_valid, tpu_in_valid, buf_sel_tpu, a_wr_en, b_wr_en}, 32'd0);
    check("arst_dims", {tpu_K, tpu_M, tpu_N, 8'd0}, 32'd0);
    check("arst_off", 32'(tpu_offset), 32'd0);
    check("arst_rsp", rsp_out, 32'd0);
    mk = 0; mm = 0; mn = 0; moff = 0; mtmo = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(7'd5, 32'd0, 32'd0, 0);
    run_cmd(7'd3, 32'd0, 32'd0, 1);
    issue(7'd9, 32'd0, 32'd0, 32'hFFFF_FFFF, 2, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
